// File: rtl/jtag_cmd_sequencer.sv
// Frames the receiver byte stream into SYNC/ADDR/DATA/CHK commands
// and issues one register write per good frame over valid/ready.
module jtag_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic              iCLOCK_50,
    input  logic              iRST_N,
    input  logic [7:0]        iBYTE,
    input  logic              iBYTE_FLAG,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [DATA_W-1:0] oWR_DATA,
    input  logic              iWR_READY,
    output logic              oBUSY,
    output logic [2:0]        oERR,
    input  logic              iERR_CLR,
    output logic [7:0]        oFRAME_CNT
);

    localparam int          NB      = DATA_W / 8;
    localparam logic [2:0]  IDX_END = 3'(NB - 1);
    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    state_t              state_q;
    logic                flag_q;
    logic [16:0]         timer_q;
    logic [2:0]          idx_q;
    logic [7:0]          chk_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [2:0]          err_q;
    logic [7:0]          cnt_q;

    logic                ev;
    logic                in_frame;
    logic                to_hit;
    logic                ck_bad;
    logic                ovr;
    logic                hs;
    logic [2:0]          err_set;
    logic [DATA_W+7:0]   shift_w;

    // Byte events, error conditions and the data shift candidate
    always_comb begin
        ev       = iBYTE_FLAG & ~flag_q;
        in_frame = (state_q == S_ADDR) || (state_q == S_DATA) ||
                   (state_q == S_CHK);
        to_hit   = in_frame && !ev && (timer_q == TO_LAST);
        ck_bad   = (state_q == S_CHK) && ev && (iBYTE != chk_q);
        ovr      = (state_q == S_WRITE) && ev;
        hs       = (state_q == S_WRITE) && wr_en_q && iWR_READY;
        err_set  = {ovr, to_hit, ck_bad};
        shift_w  = {data_q, iBYTE};
    end

    // Frame parser FSM with registered write outputs, timer and errors
    always_ff @(posedge iCLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= S_IDLE;
            flag_q    <= 1'b0;
            timer_q   <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
        end else begin
            flag_q <= iBYTE_FLAG;
            err_q  <= (iERR_CLR ? 3'b000 : err_q) | err_set;

            if (in_frame && !ev && !to_hit) begin
                timer_q <= timer_q + 17'd1;
            end else begin
                timer_q <= '0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (ev && iBYTE == SYNC_BYTE) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ev) begin
                        addr_q  <= iBYTE[ADDR_W-1:0];
                        chk_q   <= iBYTE;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (ev) begin
                        data_q <= shift_w[DATA_W-1:0];
                        chk_q  <= chk_q ^ iBYTE;
                        idx_q  <= idx_q + 3'd1;
                        if (idx_q == IDX_END) begin
                            state_q <= S_CHK;
                        end
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (ev) begin
                        if (!ck_bad) begin
                            wr_addr_q <= addr_q;
                            wr_data_q <= data_q;
                            wr_en_q   <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (hs) begin
                        wr_en_q <= 1'b0;
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oWR_EN     = wr_en_q;
    assign oWR_ADDR   = wr_addr_q;
    assign oWR_DATA   = wr_data_q;
    assign oBUSY      = (state_q != S_IDLE);
    assign oERR       = err_q;
    assign oFRAME_CNT = cnt_q;

endmodule
